// File: rtl/btn_pkg.sv
// Shared definitions for button click decoding: click event codes and FSM state encoding.
package btn_pkg;

    localparam logic [1:0] CLICK_SINGLE = 2'b01;
    localparam logic [1:0] CLICK_DOUBLE = 2'b10;
    localparam logic [1:0] CLICK_TRIPLE = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } click_state_t;

endpackage

// File: rtl/click_window_timer.sv
// Window timer for button logic: counts enabled cycles since the last clear and
// flags the final cycle of a WINDOW_CYCLES-long window.
module click_window_timer #(
    parameter int WINDOW_CYCLES = 25_000_000,
    parameter int WIN_W         = 25
) (
    input  logic CLK,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    logic [WIN_W-1:0] count_reg;

    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + WIN_W'(1);
        end
    end

    assign timeout = (count_reg == WIN_W'(WINDOW_CYCLES - 1));

endmodule

// File: rtl/btn_click_decoder.sv
// Groups one-cycle button pulses into single/double(/triple) click events held behind
// a valid/ready handshake. Define BTN_CLICK_TRIPLE_EN to enable triple-click decoding.
module btn_click_decoder
    import btn_pkg::*;
#(
    parameter int WINDOW_CYCLES = 25_000_000,
    parameter int WIN_W         = 25
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       btnPulse,
    output logic       evtValid,
    output logic [1:0] evtCode,
    input  logic       evtReady,
    output logic       evtDrop
);

`ifdef BTN_CLICK_TRIPLE_EN
    localparam logic [2:0] MAX_CLICKS = 3'd3;
`else
    localparam logic [2:0] MAX_CLICKS = 3'd2;
`endif

    click_state_t state_reg, state_next;
    logic [1:0]   clicks_reg, clicks_next;
    logic         evt_valid_reg, evt_valid_next;
    logic [1:0]   evt_code_reg, evt_code_next;
    logic         evt_drop_reg, evt_drop_next;

    logic         finalize;
    logic [1:0]   fin_code;
    logic         timer_clr;
    logic         timer_en;
    logic         timeout;

    click_window_timer #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .WIN_W         (WIN_W)
    ) u_window_timer (
        .CLK     (CLK),
        .reset   (reset),
        .clear   (timer_clr),
        .enable  (timer_en),
        .timeout (timeout)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg     <= IDLE;
            clicks_reg    <= 2'd0;
            evt_valid_reg <= 1'b0;
            evt_code_reg  <= 2'b00;
            evt_drop_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clicks_reg    <= clicks_next;
            evt_valid_reg <= evt_valid_next;
            evt_code_reg  <= evt_code_next;
            evt_drop_reg  <= evt_drop_next;
        end
    end

    // A pulse always takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_next  = state_reg;
        clicks_next = clicks_reg;
        finalize    = 1'b0;
        fin_code    = clicks_reg;
        case (state_reg)
            IDLE: begin
                if (btnPulse) begin
                    state_next  = WAIT;
                    clicks_next = 2'd1;
                end
            end
            WAIT: begin
                if (btnPulse) begin
                    if (({1'b0, clicks_reg} + 3'd1) < MAX_CLICKS) begin
                        clicks_next = clicks_reg + 2'd1;
                    end else begin
                        finalize    = 1'b1;
                        fin_code    = MAX_CLICKS[1:0];
                        state_next  = IDLE;
                        clicks_next = 2'd0;
                    end
                end else if (timeout) begin
                    finalize    = 1'b1;
                    state_next  = IDLE;
                    clicks_next = 2'd0;
                end
            end
            default: begin
                state_next  = IDLE;
                clicks_next = 2'd0;
            end
        endcase
    end

    // The slot counts as free when the held event is being taken this same cycle.
    always_comb begin
        timer_clr      = (state_reg != WAIT) || btnPulse || finalize;
        timer_en       = (state_reg == WAIT);
        evt_valid_next = evt_valid_reg && !evtReady;
        evt_code_next  = evt_code_reg;
        evt_drop_next  = 1'b0;
        if (finalize) begin
            if (!evt_valid_reg || evtReady) begin
                evt_valid_next = 1'b1;
                evt_code_next  = fin_code;
            end else begin
                evt_drop_next  = 1'b1;
            end
        end
    end

    assign evtValid = evt_valid_reg;
    assign evtCode  = evt_code_reg;
    assign evtDrop  = evt_drop_reg;

endmodule

// File: tb/tb_btn_click_decoder.sv
// Directed bench for btn_click_decoder with WINDOW_CYCLES=8; event codes are checked
// through an expected-event queue, valid/drop timing per cycle against bit masks.
module tb_btn_click_decoder;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       btnPulse = 1'b0;
    logic       evtReady = 1'b0;
    logic       evtValid;
    logic [1:0] evtCode;
    logic       evtDrop;

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    logic prev_valid = 1'b0;
    logic prev_xfer  = 1'b0;

    btn_click_decoder #(
        .WINDOW_CYCLES (8),
        .WIN_W         (4)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .btnPulse (btnPulse),
        .evtValid (evtValid),
        .evtCode  (evtCode),
        .evtReady (evtReady),
        .evtDrop  (evtDrop)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every newly presented event pops one expected code.
    always @(negedge CLK) begin
        logic [1:0] exp_code;
        if (reset) begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
        end else begin
            if (evtValid && (!prev_valid || prev_xfer)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $error("FAIL evt_unexpected: observed code=%b, required no event", evtCode);
                end else begin
                    exp_code = exp_q.pop_front();
                    assert (evtCode === exp_code) else begin
                        failures++;
                        $error("FAIL evt_code: observed=%b required=%b", evtCode, exp_code);
                    end
                    $display("event code=%b expected=%b at t=%0t", evtCode, exp_code, $time);
                end
            end
            prev_valid = evtValid;
            prev_xfer  = evtValid && evtReady;
        end
    end

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bits3(input int a, input int b, input int c);
        logic [63:0] m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        return m;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        btnPulse = 1'b0;
        evtReady = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
        checks++;
        assert (evtValid === 1'b0 && evtCode === 2'b00 && evtDrop === 1'b0) else begin
            failures++;
            $error("FAIL reset_state: observed valid=%b code=%b drop=%b required 0/00/0",
                   evtValid, evtCode, evtDrop);
        end
    endtask

    // Cycle i is observed after driving its inputs; outputs reflect edges before cycle i.
    task automatic run(input string name, input int n, input logic [63:0] pulses,
                       input logic [63:0] readys, input logic [63:0] resets,
                       input logic [63:0] valid_m, input logic [63:0] drop_m);
        for (int i = 0; i < n; i++) begin
            btnPulse = pulses[i];
            evtReady = readys[i];
            reset    = resets[i];
            checks++;
            assert (evtValid === valid_m[i]) else begin
                failures++;
                $error("FAIL %s valid@%0d: observed=%b required=%b", name, i, evtValid, valid_m[i]);
            end
            checks++;
            assert (evtDrop === drop_m[i]) else begin
                failures++;
                $error("FAIL %s drop@%0d: observed=%b required=%b", name, i, evtDrop, drop_m[i]);
            end
            @(posedge CLK);
            #1;
        end
        btnPulse = 1'b0;
        evtReady = 1'b0;
        reset    = 1'b0;
        $display("scenario %s done, checks=%0d failures=%0d", name, checks, failures);
    endtask

    initial begin
        do_reset();

        exp_q.push_back(2'b01);
        run("single", 32, bits3(0, -1, -1), bits3(30, -1, -1), '0, rng(9, 30), '0);

        do_reset();
        exp_q.push_back(2'b01);
        run("overflow", 33, bits3(0, 20, -1), bits3(31, -1, -1), '0, rng(9, 31), bits3(29, -1, -1));

        do_reset();
        run("reset_mid", 41, bits3(0, -1, -1), '0, bits3(4, -1, -1), '0, '0);
        exp_q.push_back(2'b01);
        run("after_reset", 22, bits3(10, -1, -1), bits3(19, -1, -1), '0, rng(19, 19), '0);

`ifdef BTN_CLICK_TRIPLE_EN
        do_reset();
        exp_q.push_back(2'b10);
        run("double_win", 16, bits3(0, 5, -1), bits3(14, -1, -1), '0, rng(14, 14), '0);

        do_reset();
        exp_q.push_back(2'b11);
        run("triple", 7, bits3(0, 2, 4), bits3(5, -1, -1), '0, rng(5, 5), '0);

        do_reset();
        exp_q.push_back(2'b10);
        run("pulse_at_timeout", 19, bits3(0, 8, -1), bits3(17, -1, -1), '0, rng(17, 17), '0);
`else
        do_reset();
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        run("double_fast", 15, bits3(0, 2, 4), bits3(3, 13, -1), '0,
            rng(3, 3) | rng(13, 13), '0);

        // A finalize in the same cycle as a transfer reloads the slot without a gap.
        do_reset();
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        run("reload", 16, bits3(0, 10, 12), bits3(12, 13, -1), '0, rng(9, 13), '0);
`endif

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL events_missing: observed pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_click_decoder.md
# btn_click_decoder

Classifies bursts of one-cycle button pulses into single, double or triple click events. Sits directly downstream of the button edge-detect stage: it consumes that stage's rising-edge pulse and holds a click-count event for the control logic behind a valid/ready handshake. Each button that needs click decoding gets one instance.

## Interface

Parameters:
- WINDOW_CYCLES, 25_000_000: inter-click window in CLK cycles (250 ms at 100 MHz); minimum 2.
- WIN_W, 25: timer width; must satisfy 2^WIN_W > WINDOW_CYCLES.

Ports:
- CLK  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- btnPulse  in  1  one-cycle pulse per press, from the edge stage.
- evtValid  out  1  event held and available.
- evtCode  out  2  click count: 01 single, 10 double, 11 triple.
- evtReady  in  1  consumer accepts the event.
- evtDrop  out  1  one-cycle pulse when a finished event is discarded.

## Operation

- MAX_CLICKS is 3 with BTN_CLICK_TRIPLE_EN defined and 2 without it.
- States are IDLE and WAIT. `clicks` is 2 bits. `timer` is WIN_W bits.
- IDLE, on btnPulse: set clicks=1 and timer=0, then go to WAIT. With no pulse, stay in IDLE.
- WAIT, on btnPulse with clicks+1 < MAX_CLICKS: clicks++, timer=0.
- WAIT, on btnPulse with clicks+1 == MAX_CLICKS: finalize with code MAX_CLICKS.
- WAIT, with no pulse and timer == WINDOW_CYCLES-1: finalize with code clicks.
- WAIT, otherwise: timer++.
- Finalize means:
  - If the output slot is free (evtValid==0, or evtValid&&evtReady this cycle), load evtCode and set evtValid=1.
  - Otherwise keep the old event and pulse evtDrop.
  - Go to IDLE, clear clicks and timer.
- Simultaneous pulse and timeout in WAIT: the pulse wins. It counts as a click and restarts the window.
- Handshake:
  - A transfer occurs when evtValid && evtReady.
  - evtValid and evtCode stay stable until transfer.
  - evtValid drops the cycle after transfer, unless a finalize reloads it in that same cycle.
- Reset:
  - state=IDLE, clicks=0, timer=0, evtValid=0, evtCode=2'b00, evtDrop=0.
  - A partial sequence or held event is discarded with no evtDrop.

## Timing

- Timeout path: evtValid rises WINDOW_CYCLES+1 cycles after the last pulse.
- Max-count path: evtValid rises 1 cycle after the MAX_CLICKS-th pulse.
- A pulse arriving in the cycle right after a finalize is accepted in IDLE. There is no dead cycle.
- evtDrop is asserted in the finalize cycle + 1, for exactly one cycle.
- All outputs are registered. There are no combinational paths from evtReady or btnPulse to outputs.

## Configuration

- BTN_CLICK_TRIPLE_EN defined:
  - MAX_CLICKS=3 and code 11 is reachable.
  - A double click waits for the full window before it is reported.
- BTN_CLICK_TRIPLE_EN undefined:
  - MAX_CLICKS=2, so the second pulse finalizes 10 immediately.
  - Code 11 is never produced.
  - A third quick pulse starts a new sequence.

## Structure

- Shared package btn_pkg holds:
  - the codes CLICK_SINGLE=2'b01, CLICK_DOUBLE=2'b10, CLICK_TRIPLE=2'b11;
  - the state encoding (IDLE, WAIT).
- Optional sub-module click_window_timer: clear and enable inputs, timeout output, parameterized by WINDOW_CYCLES and WIN_W. It is reusable by other window-based button logic.
- The upstream edge stage is instantiated by the parent, not inside this block.

## Test plan

All scenarios use WINDOW_CYCLES=8, with pulses numbered by cycle.
- Single click, evtReady=0: pulse at 0 -> evtValid=1, evtCode=01 from cycle 9, held through cycle 30. Set evtReady=1 at 30 -> evtValid=0 at 31.
- With BTN_CLICK_TRIPLE_EN, pulses at 0 and 5 -> code 10 valid at 14. With pulses at 0, 2, 4 -> code 11 valid at 5.
- Without BTN_CLICK_TRIPLE_EN, pulses at 0, 2, 4 -> code 10 valid at 3. After evtReady, code 01 valid at 13.
- With BTN_CLICK_TRIPLE_EN, pulse exactly at timeout: pulses at 0 and 8 -> no event at 9; code 10 valid at 17.
- Overflow: evtReady=0, pulses at 0 and 20 -> first event 01 stays held; evtDrop=1 for one cycle at 29; evtCode still 01.
- Reset mid-operation: pulse at 0, reset at 4 -> no evtValid and no evtDrop through cycle 40. A pulse at 10 then gives 01 at 19.
